// File: rtl/sha_block_word_streamer.sv
// Splits a padded multi-block message into WORD_W-bit schedule words, MSB-first, under valid/ready backpressure.
// Optional WORD_BSWAP_EN: byte-reverse each word at the output register load.
module sha_block_word_streamer #(
  parameter  int WORD_W          = 32,
  parameter  int WORDS_PER_BLOCK = 16,
  parameter  int NUM_BLOCKS      = 2,
  localparam int MSG_W           = WORD_W * WORDS_PER_BLOCK * NUM_BLOCKS,
  localparam int WI_W            = $clog2(WORDS_PER_BLOCK),
  localparam int BI_W            = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              msg_valid,
  output logic              msg_ready,
  input  logic [MSG_W-1:0]  message,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [WORD_W-1:0] word_data,
  output logic [WI_W-1:0]   word_idx,
  output logic [BI_W-1:0]   blk_idx,
  output logic              last_in_blk,
  output logic              last_in_msg
);

  if (NUM_BLOCKS < 1 || WORDS_PER_BLOCK < 2 || (WORD_W % 8) != 0) begin : g_bad_cfg
    $error("sha_block_word_streamer: need NUM_BLOCKS>=1, WORDS_PER_BLOCK>=2, WORD_W%%8==0");
  end

  typedef enum logic {IDLE, STREAM} state_t;

  state_t             state, nxt_state;
  logic [MSG_W-1:0]   msg_buf, nxt_buf;
  logic [WORD_W-1:0]  nxt_data;
  logic [WI_W-1:0]    nxt_widx;
  logic [BI_W-1:0]    nxt_bidx;
  logic               nxt_wv, nxt_mr, nxt_lb, nxt_lm;

  function automatic logic [WORD_W-1:0] fmt(input logic [WORD_W-1:0] w);
    logic [WORD_W-1:0] r;
`ifdef WORD_BSWAP_EN
    for (int b = 0; b < WORD_W/8; b++)
      r[b*8 +: 8] = w[WORD_W-8-b*8 +: 8];
`else
    r = w;
`endif
    return r;
  endfunction

  always_comb begin
    nxt_state = state;
    nxt_buf   = msg_buf;
    nxt_data  = word_data;
    nxt_widx  = word_idx;
    nxt_bidx  = blk_idx;
    nxt_wv    = word_valid;
    nxt_mr    = msg_ready;
    nxt_lb    = last_in_blk;
    nxt_lm    = last_in_msg;
    if (flush) begin
      // Abort wins over both handshakes; a coinciding transfer does not advance the buffer.
      nxt_state = IDLE;
      nxt_wv    = 1'b0;
      nxt_mr    = 1'b1;
      nxt_widx  = '0;
      nxt_bidx  = '0;
      nxt_lb    = 1'b0;
      nxt_lm    = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          nxt_mr = 1'b1;
          if (msg_valid && msg_ready) begin
            nxt_state = STREAM;
            nxt_buf   = message;
            nxt_data  = fmt(message[MSG_W-1 -: WORD_W]);
            nxt_widx  = '0;
            nxt_bidx  = '0;
            nxt_wv    = 1'b1;
            nxt_mr    = 1'b0;
            nxt_lb    = 1'b0;
            nxt_lm    = 1'b0;
          end
        end
        STREAM: begin
          if (word_ready) begin
            if (last_in_msg) begin
              nxt_state = IDLE;
              nxt_wv    = 1'b0;
              nxt_mr    = 1'b1;
              nxt_widx  = '0;
              nxt_bidx  = '0;
              nxt_lb    = 1'b0;
              nxt_lm    = 1'b0;
            end else begin
              // Top word of msg_buf is the one on word_data; the next one sits just below it.
              nxt_buf  = msg_buf << WORD_W;
              nxt_data = fmt(msg_buf[MSG_W-WORD_W-1 -: WORD_W]);
              if (last_in_blk) begin
                nxt_widx = '0;
                nxt_bidx = blk_idx + BI_W'(1);
              end else begin
                nxt_widx = word_idx + WI_W'(1);
              end
              nxt_lb = (nxt_widx == WI_W'(WORDS_PER_BLOCK-1));
              nxt_lm = nxt_lb && (nxt_bidx == BI_W'(NUM_BLOCKS-1));
            end
          end
        end
        default: nxt_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      msg_buf     <= '0;
      word_data   <= '0;
      word_idx    <= '0;
      blk_idx     <= '0;
      word_valid  <= 1'b0;
      msg_ready   <= 1'b0;
      last_in_blk <= 1'b0;
      last_in_msg <= 1'b0;
    end else begin
      state       <= nxt_state;
      msg_buf     <= nxt_buf;
      word_data   <= nxt_data;
      word_idx    <= nxt_widx;
      blk_idx     <= nxt_bidx;
      word_valid  <= nxt_wv;
      msg_ready   <= nxt_mr;
      last_in_blk <= nxt_lb;
      last_in_msg <= nxt_lm;
    end
  end

endmodule

// File: tb/tb_sha_block_word_streamer.sv
// Directed + randomized bench for sha_block_word_streamer; expected words come from a message-indexing model.
module tb_sha_block_word_streamer;
  localparam int WORD_W = 32;
  localparam int WPB    = 16;
  localparam int NB     = 2;
  localparam int MSG_W  = WORD_W * WPB * NB;
  localparam int NW     = WPB * NB;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              msg_valid = 1'b0;
  logic              msg_ready;
  logic [MSG_W-1:0]  message = '0;
  logic              word_valid;
  logic              word_ready = 1'b0;
  logic [WORD_W-1:0] word_data;
  logic [3:0]        word_idx;
  logic [0:0]        blk_idx;
  logic              last_in_blk;
  logic              last_in_msg;

  int checks = 0;
  int errors = 0;

  sha_block_word_streamer #(.WORD_W(WORD_W), .WORDS_PER_BLOCK(WPB), .NUM_BLOCKS(NB)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .message(message), .word_valid(word_valid), .word_ready(word_ready), .word_data(word_data),
    .word_idx(word_idx), .blk_idx(blk_idx), .last_in_blk(last_in_blk), .last_in_msg(last_in_msg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: word k of the message, optionally byte-reversed.
  function automatic logic [WORD_W-1:0] ref_word(input logic [MSG_W-1:0] m, input int k);
    logic [WORD_W-1:0] w;
    logic [WORD_W-1:0] r;
    w = m[MSG_W-1-k*WORD_W -: WORD_W];
`ifdef WORD_BSWAP_EN
    r = {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    r = w;
`endif
    return r;
  endfunction

  function automatic logic ready_pat(input int mode, input int cyc);
    logic r;
    case (mode)
      0: r = 1'b1;
      1: r = (cyc % 4 == 0) || (cyc % 4 == 3);
      default: r = 1'($urandom_range(0, 1));
    endcase
    return r;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, ".msg_ready"},   64'(msg_ready),   64'd0);
    check({tag, ".word_valid"},  64'(word_valid),  64'd0);
    check({tag, ".word_data"},   64'(word_data),   64'd0);
    check({tag, ".word_idx"},    64'(word_idx),    64'd0);
    check({tag, ".blk_idx"},     64'(blk_idx),     64'd0);
    check({tag, ".last_in_blk"}, 64'(last_in_blk), 64'd0);
    check({tag, ".last_in_msg"}, 64'(last_in_msg), 64'd0);
  endtask

  // abort: 0 none, 1 flush with coinciding transfer, 2 async reset; fires once abort_at words have moved.
  task automatic stream_msg(input string tag, input logic [MSG_W-1:0] m, input int mode,
                            input logic hold_valid, input logic [MSG_W-1:0] alt,
                            input int abort, input int abort_at);
    int k;
    int cyc;
    logic rdy;
    check({tag, ".ready_before_load"}, 64'(msg_ready), 64'd1);
    message   = m;
    msg_valid = 1'b1;
    step();
    if (hold_valid) message = alt;
    else msg_valid = 1'b0;
    k = 0;
    cyc = 0;
    while (k < NW && cyc < 400) begin
      if (abort != 0 && k == abort_at) break;
      rdy = ready_pat(mode, cyc);
      word_ready = rdy;
      check({tag, ".word_valid"},  64'(word_valid),  64'd1);
      check({tag, ".msg_ready"},   64'(msg_ready),   64'd0);
      check({tag, ".word_data"},   64'(word_data),   64'(ref_word(m, k)));
      check({tag, ".word_idx"},    64'(word_idx),    64'(k % WPB));
      check({tag, ".blk_idx"},     64'(blk_idx),     64'(k / WPB));
      check({tag, ".last_in_blk"}, 64'(last_in_blk), 64'(k % WPB == WPB-1));
      check({tag, ".last_in_msg"}, 64'(last_in_msg), 64'(k == NW-1));
      step();
      if (rdy) k++;
      cyc++;
    end
    if (abort == 0 || k != abort_at)
      check({tag, ".words_done"}, 64'(k), 64'(abort != 0 ? abort_at : NW));
    if (abort == 1) begin
      word_ready = 1'b1;
      flush = 1'b1;
      step();
      flush = 1'b0;
      word_ready = 1'b0;
      check({tag, ".flush_wv"},   64'(word_valid), 64'd0);
      check({tag, ".flush_mr"},   64'(msg_ready),  64'd1);
      check({tag, ".flush_widx"}, 64'(word_idx),   64'd0);
      check({tag, ".flush_bidx"}, 64'(blk_idx),    64'd0);
    end else if (abort == 2) begin
      #2 rst_n = 1'b0;
      #1 check_reset_outputs({tag, ".async_rst"});
      step();
      check_reset_outputs({tag, ".held_rst"});
      rst_n = 1'b1;
      #1 check({tag, ".mr_before_edge"}, 64'(msg_ready), 64'd0);
      step();
      check({tag, ".mr_after_edge"}, 64'(msg_ready), 64'd1);
      check({tag, ".wv_after_rst"},  64'(word_valid), 64'd0);
    end else begin
      word_ready = 1'b0;
      check({tag, ".end_wv"}, 64'(word_valid), 64'd0);
      check({tag, ".end_mr"}, 64'(msg_ready),  64'd1);
    end
  endtask

  function automatic logic [MSG_W-1:0] rand_msg();
    logic [MSG_W-1:0] m;
    for (int i = 0; i < NW; i++) m[i*WORD_W +: WORD_W] = $urandom;
    return m;
  endfunction

  logic [MSG_W-1:0] m_idx, m_a, m_b;

  initial begin
    for (int i = 0; i < NW; i++) m_idx[MSG_W-1-i*WORD_W -: WORD_W] = WORD_W'(i);
    m_a = rand_msg();
    m_b = rand_msg();

    // Reset state, then msg_ready rises one edge after release.
    #3 check_reset_outputs("reset");
    step();
    step();
    rst_n = 1'b1;
    #1 check("reset.mr_pre", 64'(msg_ready), 64'd0);
    step();
    check("reset.mr_post", 64'(msg_ready), 64'd1);

    // Index-valued message, full throughput.
    stream_msg("t1", m_idx, 0, 1'b0, '0, 0, 0);
    step();
    // Same message, 1,0,0,1 backpressure.
    stream_msg("t2", m_idx, 1, 1'b0, '0, 0, 0);
    step();
    // msg_valid held with another message during streaming; second one loads right after.
    stream_msg("t3a", m_a, 2, 1'b1, m_b, 0, 0);
    stream_msg("t3b", m_b, 0, 1'b0, '0, 0, 0);
    step();
    check("t3.no_reload_wv", 64'(word_valid), 64'd0);
    // Flush after 20 transfers, then a fresh message streams from word 0.
    stream_msg("t4a", m_a, 0, 1'b0, '0, 1, 20);
    stream_msg("t4b", m_b, 2, 1'b0, '0, 0, 0);
    step();
    // Reset mid-block 1, then a fresh message.
    stream_msg("t5a", m_b, 0, 1'b0, '0, 2, 20);
    stream_msg("t5b", m_a, 0, 1'b0, '0, 0, 0);
    step();
    // Extra randomized traffic.
    for (int r = 0; r < 3; r++) begin
      m_a = rand_msg();
      stream_msg("rand", m_a, 2, 1'b0, '0, 0, 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
